main_memory_ctrl: RTL and testbench
===================================

Name: main_memory_ctrl

Overview:
- Backing-store controller directly downstream of the cache controller.
- Consumes its RAMreadEnable / RAMwriteEnable / address / data strobes, performs multi-cycle accesses to the main RAM array, and returns fetched words with a one-cycle dataReady pulse.
- Writes (evictions) are posted, so the single-cycle write strobe is never lost.
- Reads stall until all posted writes have drained.

Parameters:
- ramWidth, 8: data word width in bits.
- addrSize, 8: address width; array depth is 2**addrSize.
- RD_LATENCY, 3: cycles from read acceptance to dataReady; must be at least 1.
- WR_LATENCY, 2: cycles from write capture to array update; must be at least 1.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- RAMreadEnable, input, 1: read request, level; held by the requester until dataReady.
- RAMwriteEnable, input, 1: write strobe, sampled every cycle; may be a single-cycle pulse.
- addr, input, addrSize: word address for the request.
- dataIn, input, ramWidth: write data.
- dataOut, output, ramWidth: read data; valid from the dataReady cycle and held until the next read completes.
- dataReady, output, 1: one-cycle pulse marking read completion.
- busy, output, 1: high while a write is in flight, a write is pending, or a read is in progress.
- wrOverflow, output, 1: sticky flag, set when a write strobe is dropped.

Behaviour:
- Reset, asynchronous, active-high: dataOut=0, dataReady=0, busy=0, wrOverflow=0, FSM=IDLE, write buffers empty, counter=0.
  - Array contents are not reset.
  - Reset mid-operation aborts the access; an in-flight or pending write is discarded.
- FSM, one-hot, states IDLE, WRITING, READING, RD_DONE:
  - IDLE -> WRITING: a write is captured or pending (write has priority).
  - IDLE -> READING: RAMreadEnable=1 and no write outstanding. addr is latched and the counter loads RD_LATENCY-1.
  - WRITING -> WRITING: counter expires and the pending buffer is valid. The pending write is promoted to in-flight and the counter reloads.
  - WRITING -> IDLE: counter expires and the pending buffer is empty.
  - READING -> RD_DONE: counter reaches 0. The array word is registered into dataOut and dataReady=1 for that cycle only.
  - RD_DONE -> IDLE: RAMreadEnable=0. RD_DONE waits while the request is still held, so one request never produces two reads.
- Write capture:
  - RAMwriteEnable=1 at any edge: addr/dataIn are captured into the in-flight slot if it is free, otherwise into a one-deep pending buffer.
  - Both slots full: the strobe is dropped and wrOverflow is set until reset.
  - The array is written at edge capture+WR_LATENCY.
  - Capture also occurs during READING/RD_DONE. The write then starts only after the FSM returns to IDLE.
- Ordering rules:
  - Read and write strobes in the same cycle: the write is performed first and the read returns the new data.
  - A read never bypasses an outstanding write.
- Latency with no writes outstanding: read accepted at edge T; dataReady asserted in the cycle following edge T+RD_LATENCY.
- Counter: $clog2(max latency)+1 bits. No wrap-around; it saturates at 0.
- Address: full-width, with no aliasing.

Optional Feature:
- Macro MEMCTRL_WR_FWD_EN.
- When defined: a read whose address matches the in-flight or pending write (pending takes precedence) skips the drain wait. It returns the buffered data with dataReady one cycle after acceptance; the posted write still completes normally.
- When undefined: reads always wait for the write drain, as in Behaviour.

Decomposition:
- Shared package mem_ctrl_pkg:
  - one-hot state encodings (4-bit);
  - default latency constants;
  - write-slot struct {valid, addr, data}.
- One natural sub-module: main_ram, a synchronous single-port array of 2**addrSize x ramWidth with registered read and write enable. main_memory_ctrl owns the FSM, the counter and the write buffers.

Test Plan:
- Read after reset: pulse rst, preload addr 0x10=0xA5, hold RAMreadEnable with addr=0x10 -> dataReady pulses once, 3 cycles after acceptance, dataOut=0xA5; busy is high during the read.
- Posted write then read: 1-cycle RAMwriteEnable with addr=0x20, dataIn=0x3C, then read 0x20 on the next cycle -> read stalls for the 2-cycle write, dataOut=0x3C, total 5 cycles to dataReady.
- Simultaneous strobes: RAMwriteEnable and RAMreadEnable in the same cycle with addr=0x05, dataIn=0x77 -> dataOut=0x77, never the stale value.
- Overflow: three back-to-back write strobes to 0x01/0x02/0x03 -> first two written; third dropped, wrOverflow=1 and held; 0x03 unchanged.
- Held request: keep RAMreadEnable high for 4 cycles after dataReady -> exactly one dataReady pulse; the next read starts only after deassertion.
- Reset mid-read: assert rst 1 cycle after read acceptance -> dataReady never pulses, all outputs 0 asynchronously, FSM=IDLE.
- With MEMCTRL_WR_FWD_EN: write 0x40=0x99, read 0x40 the next cycle -> dataReady 1 cycle after acceptance, dataOut=0x99.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the main-memory controller: one-hot FSM
// encodings, latency defaults and the posted-write slot payload.
package mem_ctrl_pkg;

  localparam int unsigned MEM_DATA_W     = 8;
  localparam int unsigned MEM_ADDR_W     = 8;
  localparam int unsigned DEF_RD_LATENCY = 3;
  localparam int unsigned DEF_WR_LATENCY = 2;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_WRITING = 4'b0010,
    ST_READING = 4'b0100,
    ST_RD_DONE = 4'b1000
  } state_e;

  typedef struct packed {
    logic                  valid;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } wr_slot_t;

  function automatic wr_slot_t mk_slot(input logic [MEM_ADDR_W-1:0] a,
                                       input logic [MEM_DATA_W-1:0] d);
    wr_slot_t s;
    s.valid = 1'b1;
    s.addr  = a;
    s.data  = d;
    return s;
  endfunction

endpackage

// File: rtl/main_memory_ctrl_ram.sv
// Synchronous single-port RAM array with registered read data.
// Contents are intentionally not reset.
module main_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/main_memory_ctrl.sv
// Backing-store controller: posted writes (in-flight + one pending slot) and
// multi-cycle reads that drain writes first. Optional MEMCTRL_WR_FWD_EN forwards buffered write data.
module main_memory_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ramWidth   = MEM_DATA_W,
  parameter int unsigned addrSize   = MEM_ADDR_W,
  parameter int unsigned RD_LATENCY = DEF_RD_LATENCY,
  parameter int unsigned WR_LATENCY = DEF_WR_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RAMreadEnable,
  input  logic                RAMwriteEnable,
  input  logic [addrSize-1:0] addr,
  input  logic [ramWidth-1:0] dataIn,
  output logic [ramWidth-1:0] dataOut,
  output logic                dataReady,
  output logic                busy,
  output logic                wrOverflow
);

  localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  wr_slot_t            infl_q, infl_d, pend_q, pend_d;
  logic [addrSize-1:0] rd_addr_q, rd_addr_d;
  logic [ramWidth-1:0] dout_q, dout_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;
  logic                fwd_q, fwd_d;
  logic [ramWidth-1:0] fwd_data_q, fwd_data_d;
  logic                hold_q, hold_d;

  logic                wr_done_c, fwd_hit_c;
  logic [ramWidth-1:0] fwd_word_c;
  logic                ram_we_c, ram_re_c;
  logic [addrSize-1:0] ram_addr_c;
  logic [ramWidth-1:0] ram_rdata;

  assign dataOut    = dout_q;
  assign dataReady  = ready_q;
  assign busy       = busy_q;
  assign wrOverflow = ovf_q;

  main_ram #(
    .DATA_W(ramWidth),
    .ADDR_W(addrSize)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we_c),
    .re_i   (ram_re_c),
    .addr_i (ram_addr_c),
    .wdata_i(infl_q.data),
    .rdata_o(ram_rdata)
  );

  // Next-state, write-slot management and RAM port control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    infl_d     = infl_q;
    pend_d     = pend_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    ready_d    = 1'b0;
    ovf_d      = ovf_q;
    fwd_d      = 1'b0;
    fwd_data_d = fwd_data_q;
    hold_d     = hold_q & RAMreadEnable;
    ram_we_c   = 1'b0;
    ram_re_c   = 1'b0;
    ram_addr_c = addr;
    wr_done_c  = (state_q == ST_WRITING) && (cnt_q == '0);

`ifdef MEMCTRL_WR_FWD_EN
    fwd_hit_c  = RAMreadEnable && !RAMwriteEnable && !fwd_q && !hold_q &&
                 ((state_q == ST_IDLE) || (state_q == ST_WRITING)) &&
                 ((pend_q.valid && (pend_q.addr == addr)) ||
                  (infl_q.valid && (infl_q.addr == addr)));
    fwd_word_c = (pend_q.valid && (pend_q.addr == addr)) ? pend_q.data : infl_q.data;
`else
    fwd_hit_c  = 1'b0;
    fwd_word_c = '0;
`endif

    if (wr_done_c) begin
      infl_d       = pend_q;
      pend_d.valid = 1'b0;
    end

    // Slots freed by this edge's commit are only reusable through promotion
    if (RAMwriteEnable) begin
      if (!infl_q.valid) begin
        infl_d = mk_slot(addr, dataIn);
      end else if (!pend_q.valid) begin
        if (wr_done_c) infl_d = mk_slot(addr, dataIn);
        else           pend_d = mk_slot(addr, dataIn);
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (fwd_q) begin
      dout_d  = fwd_data_q;
      ready_d = 1'b1;
      hold_d  = 1'b1;
    end
    if (fwd_hit_c) begin
      fwd_d      = 1'b1;
      fwd_data_d = fwd_word_c;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (infl_d.valid) begin
          state_d = ST_WRITING;
          cnt_d   = CNT_W'(WR_LATENCY - 1);
        end else if (RAMreadEnable && !hold_q && !fwd_q) begin
          state_d   = ST_READING;
          cnt_d     = CNT_W'(RD_LATENCY - 1);
          rd_addr_d = addr;
          ram_re_c  = 1'b1;
        end
      end
      ST_WRITING: begin
        ram_addr_c = infl_q.addr;
        ram_we_c   = wr_done_c;
        if (wr_done_c) begin
          if (infl_d.valid) cnt_d = CNT_W'(WR_LATENCY - 1);
          else              state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_READING: begin
        ram_addr_c = rd_addr_q;
        ram_re_c   = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RD_DONE;
          dout_d  = ram_rdata;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RD_DONE: begin
        if (!RAMreadEnable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) || infl_d.valid || pend_d.valid || fwd_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      infl_q     <= '0;
      pend_q     <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      infl_q     <= infl_d;
      pend_q     <= pend_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      ovf_q      <= ovf_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench for main_memory_ctrl: reads push expected {data, ready cycle},
// a monitor pops and compares on every dataReady pulse.
module tb_main_memory_ctrl;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       re, we;
  logic [7:0] addr, din;
  logic [7:0] dout;
  logic       drdy, busy, ovf;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

`ifdef MEMCTRL_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  main_memory_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .RAMreadEnable (re),
    .RAMwriteEnable(we),
    .addr          (addr),
    .dataIn        (din),
    .dataOut       (dout),
    .dataReady     (drdy),
    .busy          (busy),
    .wrOverflow    (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every dataReady pulse must match the oldest expected read
  always @(negedge clk) begin
    if (!rst && drdy) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("read_data", int'(dout), int'(e.data));
        check("read_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic write_pulse(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; din = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) begin
        idle = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!idle) check("idle_timeout", 0, 1);
  endtask

  // dly: edges from request setup to the dataReady cycle; hold: extra cycles request stays high
  task automatic do_read(input logic [7:0] a, input logic [7:0] exp_d, input int dly,
                         input int hold, input bit wr, input logic [7:0] wd);
    exp_t e;
    bit   got = 1'b0;
    int   extra = 0;
    re = 1'b1; addr = a;
    if (wr) begin
      we = 1'b1; din = wd;
    end
    e.data = exp_d;
    e.cyc  = cyc + dly;
    sb_q.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      we = 1'b0;
      if (i == 0) check("busy_during_read", int'(busy), 1);
      if (drdy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("read_timeout", 0, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (drdy) extra++;
    end
    if (hold > 0) check("held_request_extra_pulses", extra, 0);
    re = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; din = '0;
    repeat (2) @(negedge clk);
    check("reset_dataOut", int'(dout), 0);
    check("reset_dataReady", int'(drdy), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_wrOverflow", int'(ovf), 0);
    rst = 1'b0;
    @(negedge clk);

    write_pulse(8'h10, 8'hA5); wait_idle();
    write_pulse(8'h05, 8'h11); wait_idle();
    write_pulse(8'h03, 8'h5A); wait_idle();

    // Plain read: accept at next edge, ready RD_LATENCY edges later
    do_read(8'h10, 8'hA5, 4, 0, 1'b0, 8'h00);

    // Posted write followed by read of the same address
    write_pulse(8'h20, 8'h3C);
    do_read(8'h20, 8'h3C, FWD ? 2 : 6, 0, 1'b0, 8'h00);
    wait_idle();

    // Simultaneous strobes: write goes first, read sees new data
    do_read(8'h05, 8'h77, FWD ? 3 : 7, 0, 1'b1, 8'h77);
    wait_idle();

    // Overflow: third back-to-back strobe finds both slots full
    we = 1'b1; addr = 8'h01; din = 8'hA1;
    @(negedge clk); addr = 8'h02; din = 8'hA2;
    @(negedge clk); addr = 8'h03; din = 8'hB3;
    @(negedge clk); we = 1'b0;
    check("overflow_set", int'(ovf), 1);
    wait_idle();
    check("overflow_sticky_idle", int'(ovf), 1);
    do_read(8'h01, 8'hA1, 4, 0, 1'b0, 8'h00);
    do_read(8'h02, 8'hA2, 4, 0, 1'b0, 8'h00);
    do_read(8'h03, 8'h5A, 4, 0, 1'b0, 8'h00);
    check("overflow_sticky_after_reads", int'(ovf), 1);

    // Held request: one pulse only, next read starts after deassertion
    do_read(8'h10, 8'hA5, 4, 4, 1'b0, 8'h00);
    do_read(8'h20, 8'h3C, 4, 0, 1'b0, 8'h00);

    // Reset one cycle after read acceptance
    re = 1'b1; addr = 8'h10;
    @(negedge clk);
    check("busy_before_reset", int'(busy), 1);
    check("dataOut_before_reset", int'(dout), 8'h3C);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midread_reset_dataOut", int'(dout), 0);
    check("midread_reset_dataReady", int'(drdy), 0);
    check("midread_reset_busy", int'(busy), 0);
    check("midread_reset_wrOverflow", int'(ovf), 0);
    re = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (drdy) pulses++;
    end
    check("aborted_read_no_ready", pulses, 0);
    check("idle_after_reset", int'(busy), 0);

    // Array contents survive reset
    do_read(8'h10, 8'hA5, 4, 0, 1'b0, 8'h00);

    // Read right behind a posted write to the same address
    write_pulse(8'h40, 8'h99);
    do_read(8'h40, 8'h99, FWD ? 2 : 6, 0, 1'b0, 8'h00);
    wait_idle();
    do_read(8'h40, 8'h99, 4, 0, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
